uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1, LSB first, that recovers bytes from a UART line and presents them on a valid/ready byte interface. It sits directly downstream of the UART transmit stage, either on the board loopback or on an external RX pin, and feeds the byte consumer (command parser or ILA capture). Bit timing uses a fixed integer divider from mclk, matching the transmit stage's bit period.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rx.sv | 175 +++++++++++++++++
 tb/tb_uart_rx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package uart_pkg;

    // Receiver FSM states. PARITY is only reachable when parity is compiled in.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_rx_state_t;

    localparam int UART_CLKS_PER_BIT_DEFAULT = 102;
    localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: N-flop synchronizer for an asynchronous input, flops reset to 1 (idle line).
// Latency: STAGES mclk cycles from d to q.
// Backpressure: none.
// Ports: mclk clock, rst_n async active-low reset, d async input, q synchronized output.
`timescale 1ns/1ps
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic mclk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 (8E1 with UART_RX_PARITY_EN) UART receiver with a one-entry valid/ready output buffer.
// Latency: m_valid/error pulses one mclk after the mid-stop-bit sample.
// Backpressure: none on the line; a completed byte arriving while the buffer is full and not being read is dropped with an overrun pulse.
// Ports: mclk, rst_n (async active-low), rx (async serial in, idle high),
//        m_data/m_valid/m_ready (byte out), frame_err/parity_err/overrun (one-cycle pulses), busy.
// Optional macro UART_RX_PARITY_EN adds an even parity bit between data bit 7 and the stop bit.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    uart_rx_state_t            state, state_nxt;
    logic                      rx_s;
    logic [CW-1:0]             cnt;
    logic [2:0]                idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      sample;
    logic                      deliver;
    logic                      fe_set;
    logic                      pe_set;
    logic                      par_bad;

    uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .mclk  (mclk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    // Latched at the parity sample, consumed at the stop sample.
    logic par_err_q;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else if (state == START) begin
            par_err_q <= 1'b0;
        end else if (state == PARITY && sample) begin
            par_err_q <= rx_s ^ (^shreg);
        end
    end

    assign par_bad = par_err_q;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sample    = 1'b0;
        deliver   = 1'b0;
        fe_set    = 1'b0;
        pe_set    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) state_nxt = START;
            end
            START: begin
                // Mid-start sample; a high line here means the falling edge was a glitch.
                sample = (cnt == CNT_HALF);
                if (sample) state_nxt = rx_s ? IDLE : DATA;
            end
            DATA: begin
                sample = (cnt == CNT_FULL);
                if (sample && idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                sample = (cnt == CNT_FULL);
                if (sample) state_nxt = STOP;
            end
`endif
            STOP: begin
                sample = (cnt == CNT_FULL);
                if (sample) begin
                    if (!rx_s) begin
                        fe_set    = 1'b1;
                        pe_set    = par_bad;
                        state_nxt = WAIT_HIGH;
                    end else if (par_bad) begin
                        pe_set    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        deliver   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                // Hold off until the line returns high so a break is not read as start bits.
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= fe_set;
            parity_err <= pe_set;
            overrun    <= 1'b0;

            // Counter restarts on every state entry and after each bit sample.
            if (state_nxt != state || sample || state == IDLE || state == WAIT_HIGH) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (state == START) begin
                idx <= '0;
            end else if (state == DATA && sample) begin
                shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                idx   <= idx + 1'b1;
            end

            // One-entry buffer: a same-cycle read frees the slot for the new byte.
            if (deliver) begin
                if (!m_valid || m_ready) begin
                    m_data  <= shreg;
                    m_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB  = 102;
    localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME_BITS = PAR_EN ? 11 : 10;
    // Inputs change 2 ns after a rising edge; outputs are sampled on falling edges.
    // Start drive -> first falling edge with m_valid high.
    localparam int LAT = SYNC + 2 + CPB / 2 + (FRAME_BITS - 1) * CPB;

    logic       mclk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .mclk       (mclk),
        .rst_n      (rst_n),
        .rx         (rx),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 mclk = ~mclk;

    int n_chk = 0;
    int n_err = 0;

    // Monitor: observed stream and pulse counts.
    int         cyc = 0;
    int         fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, vld_cycles = 0, rise_cyc = 0;
    logic       prev_vld = 1'b0;
    logic [7:0] got_q[$];

    always @(negedge mclk) begin
        cyc++;
        if (m_valid && !prev_vld) rise_cyc = cyc;
        prev_vld = m_valid;
        if (m_valid) vld_cycles++;
        if (m_valid && m_ready) got_q.push_back(m_data);
        if (frame_err) fe_cnt++;
        if (parity_err) pe_cnt++;
        if (overrun) ov_cnt++;
    end

    // Reference model: frame-level outcome with a one-slot buffer.
    logic [7:0] exp_q[$];
    int         exp_fe = 0, exp_pe = 0, exp_ov = 0;
    bit         mdl_full = 1'b0;
    logic [7:0] mdl_byte = 8'h00;
    int         start_cyc = 0;

    task automatic model_frame(input logic [7:0] d, input bit stop, input bit par);
        bit perr;
        perr = PAR_EN && (par != (^d));
        if (perr) exp_pe++;
        if (!stop) exp_fe++;
        if (stop && !perr) begin
            if (mdl_full) exp_ov++;
            else if (m_ready) exp_q.push_back(d);
            else begin
                mdl_full = 1'b1;
                mdl_byte = d;
            end
        end
    endtask

    task automatic model_ready_rise();
        if (mdl_full) exp_q.push_back(mdl_byte);
        mdl_full = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge mclk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_pulses(input string tag);
        chk({tag, "_frame_err"}, 32'(fe_cnt), 32'(exp_fe));
        chk({tag, "_parity_err"}, 32'(pe_cnt), 32'(exp_pe));
        chk({tag, "_overrun"}, 32'(ov_cnt), 32'(exp_ov));
    endtask

    // abort_at > 0 stops driving after that many cycles (frame not modelled).
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit par, input int abort_at);
        logic [10:0] bits;
        int t;
        t = 0;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (PAR_EN) begin
            bits[9]  = par;
            bits[10] = stop;
        end else begin
            bits[9] = stop;
        end
        for (int b = 0; b < FRAME_BITS; b++) begin
            rx = bits[b];
            if (b == 0) start_cyc = cyc;
            for (int c = 0; c < CPB; c++) begin
                tick(1);
                t++;
                if (abort_at != 0 && t == abort_at) return;
            end
        end
        model_frame(d, stop, par);
    endtask

    initial begin
        logic [7:0] d;
        int v0;

        rst_n = 1'b0;
        rx = 1'b1;
        m_ready = 1'b1;
        tick(5);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'h00);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(10);

        // Single byte, exact latency and one-cycle valid.
        v0 = vld_cycles;
        d = 8'h48;
        send_frame(d, 1'b1, ^d, 0);
        tick(CPB);
        check_stream("h48");
        chk("h48_latency", 32'(rise_cyc - start_cyc), 32'(LAT));
        chk("h48_vld_cycles", 32'(vld_cycles - v0), 32'd1);
        check_pulses("h48");

        // Random back-to-back frames with zero idle.
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1, ^d, 0);
        end
        tick(CPB);
        check_stream("rand_b2b");
        check_pulses("rand_b2b");

        // Random frames with random idle gaps.
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1, ^d, 0);
            tick($urandom_range(1, 2 * CPB));
        end
        tick(CPB);
        check_stream("rand_gap");

        // Short start glitch.
        v0 = vld_cycles;
        rx = 1'b0;
        tick(20);
        chk("glitch_busy_hi", 32'(busy), 32'd1);
        rx = 1'b1;
        tick(60);
        chk("glitch_busy_lo", 32'(busy), 32'd0);
        chk("glitch_no_valid", 32'(vld_cycles - v0), 32'd0);
        check_pulses("glitch");

        // Framing error followed by a break.
        d = 8'h55;
        send_frame(d, 1'b0, ^d, 0);
        tick(500);
        chk("break_busy", 32'(busy), 32'd1);
        check_stream("break");
        check_pulses("break");
        rx = 1'b1;
        tick(6);
        chk("break_busy_lo", 32'(busy), 32'd0);
        d = 8'h6C;
        send_frame(d, 1'b1, ^d, 0);
        tick(CPB);
        check_stream("after_break");
        check_pulses("after_break");

        // Overrun with the consumer stalled.
        m_ready = 1'b0;
        d = 8'h65;
        send_frame(d, 1'b1, ^d, 0);
        d = 8'h6C;
        send_frame(d, 1'b1, ^d, 0);
        tick(CPB);
        chk("ovr_m_valid", 32'(m_valid), 32'd1);
        chk("ovr_m_data", 32'(m_data), 32'h65);
        chk("ovr_count_once", 32'(ov_cnt), 32'd1);
        check_pulses("ovr");
        m_ready = 1'b1;
        model_ready_rise();
        tick(3);
        chk("ovr_drain_valid", 32'(m_valid), 32'd0);
        check_stream("ovr");

        // Reset during data bit 4 while the buffer holds a byte.
        m_ready = 1'b0;
        d = 8'h5A;
        send_frame(d, 1'b1, ^d, 0);
        tick(CPB);
        chk("prerst_valid", 32'(m_valid), 32'd1);
        d = 8'h21;
        send_frame(d, 1'b1, ^d, CPB * 5 + CPB / 2);
        chk("prerst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        mdl_full = 1'b0;
        tick(2);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_m_data", 32'(m_data), 32'h00);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_errs", 32'({frame_err, parity_err, overrun}), 32'd0);
        rx = 1'b1;
        tick(5);
        rst_n = 1'b1;
        m_ready = 1'b1;
        tick(CPB);
        d = 8'h0A;
        send_frame(d, 1'b1, ^d, 0);
        tick(CPB);
        check_stream("after_rst");
        check_pulses("after_rst");

`ifdef UART_RX_PARITY_EN
        // Bad parity dropped, good parity delivered, then random parity.
        d = 8'h01;
        send_frame(d, 1'b1, 1'b0, 0);
        d = 8'h03;
        send_frame(d, 1'b1, 1'b0, 0);
        tick(CPB);
        check_stream("par_directed");
        check_pulses("par_directed");
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1, 1'($urandom), 0);
        end
        tick(CPB);
        check_stream("par_rand");
        check_pulses("par_rand");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
